// File: rtl/stepper_pkg.sv
// Shared types and defaults for the stepper axis: sequencer states, direction codes, timing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STEP_HI = 2'd2,
        STEP_LO = 2'd3
    } seq_state_t;

    localparam logic CW  = 1'b1;
    localparam logic CCW = 1'b0;

    // 1 ms high / 1 ms low and 200 ns DIR setup at 50 MHz; also used by the encoder-jog path
    localparam int DEFAULT_PULSE_LENGTH = 50000;
    localparam int DEFAULT_DIR_SETUP    = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stepper_phase_timer.sv
// Down-counter timing one sequencer phase: load N-1, expire is high in the phase's last cycle.
// Latency: expire asserts load_val cycles after the load edge (immediately when load_val==0).
// Backpressure: none; load wins over counting.
module stepper_phase_timer #(
    parameter int W = 4
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Count toward zero and park there until the next phase loads a new length
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/stepper_move_sequencer.sv
// Runs whole A4988 moves: DIR setup, then N STEP pulses, tracking signed position; optional limits (STEPPER_LIMIT_EN).
// Latency: accept -> first STEP rise after DIR_SETUP cycles; move ends DIR_SETUP+2*N*PULSE_LENGTH cycles after accept.
// Backpressure: cmd_ready only in IDLE; an offered command is held by the source, never dropped or queued.
module stepper_move_sequencer
    import stepper_pkg::*;
#(
    parameter int PULSE_LENGTH = DEFAULT_PULSE_LENGTH,
    parameter int DIR_SETUP    = DEFAULT_DIR_SETUP,
    parameter int CNT_W        = 16,
    parameter int POS_W        = 24
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic                    abort,
`ifdef STEPPER_LIMIT_EN
    input  logic                    limit_cw,
    input  logic                    limit_ccw,
`endif
    output logic                    dir,
    output logic                    step,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic signed [POS_W-1:0] position,
    output logic [CNT_W-1:0]        steps_left
);

    localparam int TMR_W = $clog2(max_int(PULSE_LENGTH, DIR_SETUP) + 1);
    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_LENGTH - 1);
    localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(DIR_SETUP - 1);
    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    seq_state_t       state, state_nxt;
    logic             accept;
    logic             abort_eff;
    logic             abort_seen;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expire;
    logic             rise;
    logic             move_end;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;

`ifdef STEPPER_LIMIT_EN
    // Only the limit in the direction of travel stops the move
    assign abort_eff = abort || ((dir == CW) ? limit_cw : limit_ccw);
`else
    assign abort_eff = abort;
`endif

    stepper_phase_timer #(.W(TMR_W)) u_timer (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase sequencing: abort cuts SETUP short but only ever ends a move at a LO->HI boundary
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = PULSE_LOAD;
        rise      = 1'b0;
        move_end  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (cmd_steps != '0)) begin
                    state_nxt = SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (abort_eff) begin
                    state_nxt = IDLE;
                    move_end  = 1'b1;
                end else if (tmr_expire) begin
                    state_nxt = STEP_HI;
                    tmr_load  = 1'b1;
                    rise      = 1'b1;
                end
            end
            STEP_HI: begin
                if (tmr_expire) begin
                    state_nxt = STEP_LO;
                    tmr_load  = 1'b1;
                end
            end
            STEP_LO: begin
                if (tmr_expire) begin
                    if ((steps_left == '0) || abort_seen || abort_eff) begin
                        state_nxt = IDLE;
                        move_end  = 1'b1;
                    end else begin
                        state_nxt = STEP_HI;
                        tmr_load  = 1'b1;
                        rise      = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pin outputs, position and move bookkeeping
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            dir        <= CCW;
            step       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            position   <= '0;
            steps_left <= '0;
            abort_seen <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            step    <= (state_nxt == STEP_HI);
            if (accept) begin
                dir        <= cmd_dir;
                steps_left <= cmd_steps;
                if (cmd_steps == '0) begin
                    done <= 1'b1;
                end
            end
            if (rise) begin
                position   <= (dir == CW) ? position + POS_ONE : position - POS_ONE;
                steps_left <= steps_left - CNT_ONE;
                abort_seen <= 1'b0;
            end else if ((state == STEP_HI) || (state == STEP_LO)) begin
                abort_seen <= abort_seen || abort_eff;
            end
            // Any end with steps still pending is an early end
            if (move_end) begin
                done    <= 1'b1;
                aborted <= (steps_left != '0);
            end
        end
    end

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Bench for stepper_move_sequencer with PULSE_LENGTH=4, DIR_SETUP=2, POS_W=4.
// Table vectors, hand sequences for back-to-back/reset/wrap/limits, then random moves vs a model.
// Works with or without STEPPER_LIMIT_EN.
module tb_stepper_move_sequencer;

    localparam int PL    = 4;
    localparam int DS    = 2;
    localparam int CNT_W = 16;
    localparam int POS_W = 4;

    logic                    CLOCK_50 = 1'b0;
    logic                    reset;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_dir;
    logic [CNT_W-1:0]        cmd_steps;
    logic                    abort;
    logic                    dir;
    logic                    step;
    logic                    busy;
    logic                    done;
    logic                    aborted;
    logic signed [POS_W-1:0] position;
    logic [CNT_W-1:0]        steps_left;
`ifdef STEPPER_LIMIT_EN
    logic                    limit_cw  = 1'b0;
    logic                    limit_ccw = 1'b0;
`endif

    int n_vec = 0;
    int n_bad = 0;
    logic signed [POS_W-1:0] mdl_pos;

    always #5 CLOCK_50 = ~CLOCK_50;

    stepper_move_sequencer #(
        .PULSE_LENGTH (PL),
        .DIR_SETUP    (DS),
        .CNT_W        (CNT_W),
        .POS_W        (POS_W)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .abort      (abort),
`ifdef STEPPER_LIMIT_EN
        .limit_cw   (limit_cw),
        .limit_ccw  (limit_ccw),
`endif
        .dir        (dir),
        .step       (step),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .position   (position),
        .steps_left (steps_left)
    );

    typedef struct {
        logic d;
        int   n;
        int   ab;     // relative cycle holding abort for one cycle, -1 = none
        int   dpos;
        int   left;
        logic exab;
        int   len;    // relative cycle of the done pulse
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic s, input logic b, input logic dn, input logic dr,
                                       input logic rd, input logic [3:0] p, input logic [15:0] l);
        return {39'd0, s, b, dn, dr, rd, p, l};
    endfunction

    // Issue one move and check every cycle up to its done against the step/phase arithmetic.
    // Entered and left just after a falling edge.
    task automatic run_move(input logic d, input int n, input int ab,
                            output int got_len, output logic [3:0] got_pos,
                            output logic [15:0] got_left, output logic got_ab);
        int nact, len, started, wait_cnt;
        logic exp_ab, exp_step;
        logic [3:0] p0, pe;
        if (n == 0) begin
            nact = 0;
            len  = 0;
        end else begin
            nact = n;
            len  = DS + 2 * PL * n;
            if (ab >= 0 && ab < DS) begin
                nact = 0;
                len  = ab + 1;
            end else if (ab >= DS && (ab - DS) / (2 * PL) < n) begin
                nact = (ab - DS) / (2 * PL) + 1;
                len  = DS + 2 * PL * nact;
            end
        end
        exp_ab   = (nact < n);
        got_len  = -1;
        got_pos  = 'x;
        got_left = 'x;
        got_ab   = 1'bx;
        wait_cnt = 0;
        while (!cmd_ready && wait_cnt < 100) begin
            @(negedge CLOCK_50);
            wait_cnt++;
        end
        if (!cmd_ready) check("ready_timeout", 64'd0, 64'd1);
        p0        = mdl_pos;
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_steps = CNT_W'(n);
        @(negedge CLOCK_50);
        cmd_valid = 1'b0;
        for (int c = 0; c <= len; c++) begin
            abort   = (c == ab);
            started = (c < DS || n == 0) ? 0 : (c - DS) / (2 * PL) + 1;
            if (started > nact) started = nact;
            exp_step = (c < len) && (c >= DS) && (((c - DS) % (2 * PL)) < PL);
            pe = d ? p0 + 4'(started) : p0 - 4'(started);
            check($sformatf("move d%0d n%0d c%0d", d, n, c),
                  pk(step, busy, done, dir, cmd_ready, position, steps_left),
                  pk(exp_step, c < len, c == len, d, !(c < len), pe, 16'(n - started)));
            if (done && got_len < 0) begin
                got_len  = c;
                got_pos  = position;
                got_left = steps_left;
                got_ab   = aborted;
            end
            if (c == len) begin
                check($sformatf("aborted d%0d n%0d", d, n), {63'd0, aborted}, {63'd0, exp_ab});
                mdl_pos = pe;
            end
            if (c < len) @(negedge CLOCK_50);
        end
        abort = 1'b0;
    endtask

    initial begin
        int k, glen;
        logic [3:0] gpos;
        logic [15:0] gleft;
        logic gab, d;
        int n, ab;
        logic [3:0] ep;

        tbl[0] = '{1'b1, 3, -1,  3, 0, 1'b0, 26};  // plain CW move
        tbl[1] = '{1'b1, 0, -1,  0, 0, 1'b0,  0};  // zero-step command
        tbl[2] = '{1'b0, 5, 11, -2, 3, 1'b1, 18};  // abort inside 2nd high phase
        tbl[3] = '{1'b1, 2,  1,  0, 2, 1'b1,  2};  // abort during DIR setup
        tbl[4] = '{1'b1, 2, 17,  2, 0, 1'b0, 18};  // abort in last low of last step: not early
        tbl[5] = '{1'b0, 1,  0,  0, 1, 1'b1,  1};  // abort in first setup cycle
        tbl[6] = '{1'b1, 4,  9,  1, 3, 1'b1, 10};  // abort in last low cycle of pulse 1

        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 16'd3;
        abort     = 1'b0;
        mdl_pos   = '0;

        // Reset held with a command offered: nothing moves, nothing accepted
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            check($sformatf("reset c%0d", i),
                  pk(step, busy, done, dir, aborted, position, steps_left), 64'd0);
        end
        reset     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge CLOCK_50);
        check("post_reset_idle", pk(step, busy, done, dir, cmd_ready, position, steps_left),
              pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'd0));

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            ep = mdl_pos + 4'(tbl[i].dpos);
            run_move(tbl[i].d, tbl[i].n, tbl[i].ab, glen, gpos, gleft, gab);
            check($sformatf("tbl%0d len", i), 64'(glen), 64'(tbl[i].len));
            check($sformatf("tbl%0d pos", i), {60'd0, gpos}, {60'd0, ep});
            check($sformatf("tbl%0d left", i), {48'd0, gleft}, 64'(tbl[i].left));
            check($sformatf("tbl%0d aborted", i), {63'd0, gab}, {63'd0, tbl[i].exab});
        end

        // Back-to-back: second command held valid through a CW move
        @(negedge CLOCK_50);
        ep        = mdl_pos;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 16'd1;
        @(negedge CLOCK_50);
        cmd_dir = 1'b0;
        k = 0;
        while (!done && k < 30) begin
            @(negedge CLOCK_50);
            k++;
        end
        check("b2b first len", 64'(k), 64'(DS + 2 * PL));
        check("b2b done cycle", {61'd0, dir, cmd_ready, position == ep + 4'd1}, 64'b111);
        @(negedge CLOCK_50);
        check("b2b accept s0", {61'd0, busy, dir, step}, 64'b100);
        @(negedge CLOCK_50);
        check("b2b accept s1", {61'd0, busy, dir, step}, 64'b100);
        cmd_valid = 1'b0;
        @(negedge CLOCK_50);
        check("b2b rise", {60'd0, step, dir, position == ep, busy}, 64'b1011);
        k = 2;
        while (!done && k < 30) begin
            @(negedge CLOCK_50);
            k++;
        end
        check("b2b second len", 64'(k), 64'(DS + 2 * PL));
        check("b2b second pos", {60'd0, position}, {60'd0, ep});
        mdl_pos = ep;

        // Reset in the middle of a high phase
        @(negedge CLOCK_50);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 16'd3;
        @(negedge CLOCK_50);
        cmd_valid = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("midmove high", {62'd0, step, busy}, 64'b11);
        reset = 1'b1;
        @(negedge CLOCK_50);
        check("midmove reset", pk(step, busy, done, dir, aborted, position, steps_left), 64'd0);
        reset   = 1'b0;
        mdl_pos = '0;
        @(negedge CLOCK_50);

        // Position wrap: 6 -> 7 -> -8 -> -7
        run_move(1'b1, 6, -1, glen, gpos, gleft, gab);
        run_move(1'b1, 3, -1, glen, gpos, gleft, gab);
        check("wrap final", {60'd0, gpos}, 64'h9);

`ifdef STEPPER_LIMIT_EN
        // CW limit raised during the 2nd low phase: no 3rd rise
        @(negedge CLOCK_50);
        ep        = mdl_pos;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 16'd3;
        @(negedge CLOCK_50);
        cmd_valid = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            if (k == DS + 3 * PL) limit_cw = 1'b1;
            @(negedge CLOCK_50);
            k++;
        end
        check("limit len", 64'(k), 64'(DS + 4 * PL));
        check("limit end", {44'd0, aborted, position, steps_left[14:0]},
              {44'd0, 1'b1, ep + 4'd2, 15'd1});
        limit_cw = 1'b0;
        mdl_pos  = ep + 4'd2;
        // Command toward an asserted limit: no steps at all
        @(negedge CLOCK_50);
        limit_ccw = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_steps = 16'd2;
        @(negedge CLOCK_50);
        cmd_valid = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            @(negedge CLOCK_50);
            k++;
        end
        check("limit setup len", 64'(k), 64'd1);
        check("limit setup end", {44'd0, aborted, position, steps_left[14:0]},
              {44'd0, 1'b1, mdl_pos, 15'd2});
        limit_ccw = 1'b0;
        @(negedge CLOCK_50);
`endif

        // Random moves against the model
        for (int i = 0; i < 40; i++) begin
            d  = 1'($urandom_range(0, 1));
            n  = $urandom_range(0, 4);
            ab = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, DS + 8 * PL);
            run_move(d, n, ab, glen, gpos, gleft, gab);
            if (($urandom_range(0, 3)) == 0) @(negedge CLOCK_50);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

endmodule
